// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
// Leading-zero blanking is compiled in only when SEVEN_SEG_LZB_EN is defined.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_ZERO  = 7'h40;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ON
  } scan_state_t;

endpackage

// File: rtl/seven_seg_lzb_mask.sv
// Leading-zero suppress mask: digit j >= 1 is blanked when it and every more
// significant digit show a bare "0" with no decimal point.
module seven_seg_lzb_mask
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  seg_t                  snap_seg_i [NUM_DIGITS],
  input  logic [NUM_DIGITS-1:0] snap_dp_i,
  output logic [NUM_DIGITS-1:0] suppress_o
);

  logic zero_run;

  // Walk from the most significant digit down; the run breaks at the first
  // non-zero digit or lit decimal point. Digit 0 is never suppressed.
  always_comb begin
    zero_run   = 1'b1;
    suppress_o = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run && (snap_seg_i[k] == SEG_ZERO) && !snap_dp_i[k];
      suppress_o[k] = zero_run;
    end
  end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with dead-time blanking, 16-level PWM and
// frame-start snapshot. Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  seg_t                  seg_in [NUM_DIGITS],
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  en,
  input  logic [3:0]            brightness,
  output seg_t                  seg_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  frame_tick,
  output scan_state_t           dbg_state
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  // With no dead time the gap phase collapses and ON follows ON directly.
  localparam scan_state_t   GAP_STATE  = (BLANK_TICKS > 0) ? BLANK : ON;

  scan_state_t           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            pwm_q, pwm_d;
  logic                  frame_start;

  seg_t                  snap_seg_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dp_q;
  logic [NUM_DIGITS-1:0] suppress;

  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q;

`ifdef SEVEN_SEG_LZB_EN
  seven_seg_lzb_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lzb_mask (
    .snap_seg_i (snap_seg_q),
    .snap_dp_i  (snap_dp_q),
    .suppress_o (suppress)
  );
`else
  assign suppress = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pwm_d       = pwm_q;
    frame_start = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      pwm_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_start = 1'b1;
          state_d     = GAP_STATE;
          idx_d       = '0;
          cnt_d       = '0;
          pwm_d       = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ON;
            cnt_d   = '0;
            pwm_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ON: begin
          pwm_d = pwm_q + 4'd1;
          if (cnt_q == DIGIT_LAST) begin
            state_d = GAP_STATE;
            cnt_d   = '0;
            pwm_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d       = '0;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Gating on en blanks the display on the edge right after en drops.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    if (en && (state_q == ON) && !suppress[idx_q]) begin
      seg_d = snap_seg_q[idx_q];
      dp_d  = ~snap_dp_q[idx_q];
      if (pwm_q <= brightness) an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      pwm_q        <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
      snap_dp_q    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) snap_seg_q[i] <= SEG_BLANK;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_start;
      if (frame_start) begin
        snap_seg_q <= seg_in;
        snap_dp_q  <= dp_in;
      end
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_tick = frame_tick_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux: a 4/2-tick scanner for frame timing
// and a 16/0-tick scanner for PWM duty and the no-blank path.
module tb_seven_seg_scan_mux;
  import seven_seg_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  seg_t        seg_in [N];
  logic [N-1:0] dp_in = '0;
  logic [3:0]  brightness = 4'd15;

  seg_t        seg_out, seg_out2;
  logic        dp_out, dp_out2;
  logic [N-1:0] an_out, an_out2;
  logic        frame_tick, frame_tick2;
  scan_state_t dbg_state, dbg_state2;

  int checks   = 0;
  int failures = 0;

  seg_t pat_a [N] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  seg_t pat_b [N] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg_t pat_z [N] = '{7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  seg_t pat_0 [N] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [N-1:0] dp_a = 8'b1010_0101;
  logic [N-1:0] one  = 8'h01;

  always #5 clk = ~clk;

  seven_seg_scan_mux #(
    .NUM_DIGITS (N),
    .DIGIT_TICKS(4),
    .BLANK_TICKS(2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .en         (en),
    .brightness (brightness),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  seven_seg_scan_mux #(
    .NUM_DIGITS (N),
    .DIGIT_TICKS(16),
    .BLANK_TICKS(0)
  ) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .en         (en),
    .brightness (brightness),
    .seg_out    (seg_out2),
    .dp_out     (dp_out2),
    .an_out     (an_out2),
    .frame_tick (frame_tick2),
    .dbg_state  (dbg_state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_seg"}, 32'(seg_out), 32'h7F);
    check({tag, "_dp"},  32'(dp_out),  32'h1);
    check({tag, "_an"},  32'(an_out),  32'hFF);
  endtask

  // Entered one cycle after frame_tick rose; leaves on the next frame_tick.
  task automatic check_frame(input seg_t exp_seg [N], input logic [N-1:0] exp_dp,
                             input logic [N-1:0] shown, input logic [3:0] bright,
                             input int chg_k, input seg_t chg_seg [N]);
    int d, p;
    seg_t e_seg;
    logic e_dp;
    logic [N-1:0] e_an;
    brightness = bright;
    for (int k = 2; k <= 49; k++) begin
      if (k == chg_k) seg_in = chg_seg;
      tick();
      d = (k - 2) / 6;
      p = (k - 2) % 6;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_an  = '1;
      if (p >= 2 && shown[d]) begin
        e_seg = exp_seg[d];
        e_dp  = ~exp_dp[d];
        if ((p - 2) <= int'(bright)) e_an = ~(one << d);
      end
      check($sformatf("frame_k%0d_seg", k), 32'(seg_out), 32'(e_seg));
      check($sformatf("frame_k%0d_dp", k),  32'(dp_out),  32'(e_dp));
      check($sformatf("frame_k%0d_an", k),  32'(an_out),  32'(e_an));
      check($sformatf("frame_k%0d_tick", k), 32'(frame_tick), (k == 49) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    int d, p;
    logic [N-1:0] e_an;
    seg_in = pat_a;
    dp_in  = dp_a;
    #1 rst = 1'b1;
    #1;
    check_off("reset_async");
    check("reset_tick", 32'(frame_tick), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_off($sformatf("idle_c%0d", i));
      check($sformatf("idle_c%0d_tick", i), 32'(frame_tick), 32'h0);
    end

    // First frame, then a frame with a mid-frame input change, then the new frame.
    en = 1'b1;
    tick();
    check("start_tick", 32'(frame_tick), 32'h1);
    check_off("start");
    check_frame(pat_a, dp_a, '1, 4'd15, 0, pat_a);
    check_frame(pat_a, dp_a, '1, 4'd15, 20, pat_b);
    check_frame(pat_b, dp_a, '1, 4'd15, 0, pat_b);
    check_frame(pat_b, dp_a, '1, 4'd1, 0, pat_b);

    // Drop en while digit 5 is lit.
    brightness = 4'd15;
    repeat (34) tick();
    check("dig5_an", 32'(an_out), 32'hDF);
    check("dig5_seg", 32'(seg_out), 32'(pat_b[5]));
    en = 1'b0;
    tick();
    check_off("en_drop");
    check("en_drop_state", 32'(dbg_state), 32'(IDLE));
    tick();
    check_off("en_drop2");
    check("en_drop2_tick", 32'(frame_tick), 32'h0);
    en = 1'b1;
    tick();
    check("restart_tick", 32'(frame_tick), 32'h1);
    check_frame(pat_b, dp_a, '1, 4'd15, 0, pat_b);

    // PWM on the 16-tick scanner: duty 3 on digit 0, duty 0 on digit 1.
    en = 1'b0;
    repeat (2) tick();
    en = 1'b1;
    tick();
    check("d16_tick", 32'(frame_tick2), 32'h1);
    check("d16_an_first", 32'(an_out2), 32'hFF);
    for (int k = 2; k <= 33; k++) begin
      d = (k - 2) / 16;
      p = (k - 2) % 16;
      brightness = (d == 0) ? 4'd3 : 4'd0;
      tick();
      e_an = (p <= int'(brightness)) ? ~(one << d) : '1;
      check($sformatf("d16_k%0d_an", k), 32'(an_out2), 32'(e_an));
      check($sformatf("d16_k%0d_seg", k), 32'(seg_out2), 32'(pat_b[d]));
    end

    // Asynchronous reset while the short scanner has digit 5 lit.
    brightness = 4'd15;
    tick();
    check("pre_rst_an", 32'(an_out), 32'hDF);
    #1 rst = 1'b1;
    #1;
    check_off("rst_mid");
    check("rst_mid_tick", 32'(frame_tick), 32'h0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mid_an2", 32'(an_out2), 32'hFF);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_off("post_rst");

    // Leading-zero inputs: "00000123", then all zeros.
    seg_in = pat_z;
    dp_in  = '0;
    en = 1'b1;
    tick();
    check("lzb_tick", 32'(frame_tick), 32'h1);
`ifdef SEVEN_SEG_LZB_EN
    check_frame(pat_z, '0, 8'h07, 4'd15, 20, pat_0);
    check_frame(pat_0, '0, 8'h01, 4'd15, 0, pat_0);
`else
    check_frame(pat_z, '0, 8'hFF, 4'd15, 20, pat_0);
    check_frame(pat_0, '0, 8'hFF, 4'd15, 0, pat_0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
